// File: rtl/ddr2_blk_rdwr_fifo_72b_2_64b_pkg.sv
// Shared widths and group constants for the DDR2 read-side 72b->64b repacker.
//   IN_WIDTH    : width of words returned from DRAM
//   OUT_WIDTH   : width of words handed to the packet-side consumer
//   GROUP_WORDS : input words per repack group (8 in -> 9 out)
package ddr2_blk_rdwr_fifo_72b_2_64b_pkg;

  localparam int unsigned IN_WIDTH    = 72;
  localparam int unsigned OUT_WIDTH   = 64;
  localparam int unsigned GROUP_WORDS = 8;

  typedef logic [3:0] cnt_t;

  localparam cnt_t CNT_FLUSH = cnt_t'(GROUP_WORDS);

  // Top bit of the 64-bit window that lines up with group position cnt
  // inside a 136-bit {residual-space, in_head} concatenation.
  function automatic logic [7:0] slice_top(input cnt_t cnt);
    return 8'd71 + {1'b0, cnt, 3'b000};
  endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fallthrough FIFO.
//   clk, rst     : clock, synchronous active-high reset (empties the FIFO)
//   din, wr_en   : write port
//   rd_en        : pop strobe; dout is the current head while !empty
//   nearly_full  : at most one free entry remains
//   empty        : no entries
module fallthrough_small_fifo #(
  parameter int unsigned WIDTH          = 72,
  parameter int unsigned MAX_DEPTH_BITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);

  localparam int unsigned DEPTH = 1 << MAX_DEPTH_BITS;

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   depth;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      depth  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   depth <= depth + 1'b1;
        2'b01:   depth <= depth - 1'b1;
        default: depth <= depth;
      endcase
    end
  end

  assign dout        = mem[rd_ptr];
  assign empty       = (depth == '0);
  assign nearly_full = (depth >= (MAX_DEPTH_BITS+1)'(DEPTH - 1));

endmodule

// File: rtl/ddr2_blk_rdwr_fifo_72b_2_64b.sv
// Read-side width converter: repacks 72-bit DRAM words into 64-bit words,
// 8 inputs -> 9 outputs per group, byte order MSB-first preserved.
//   clk, rst    : clock, synchronous active-high reset
//   wr_data     : 72-bit input word, wr_en writes it, full = input nearly full
//   rd_data     : fallthrough head of output FIFO, popped by rd_en
//   rd_data_d1  : word popped on the previous rd_en
//   empty       : output FIFO empty
module ddr2_blk_rdwr_fifo_72b_2_64b
  import ddr2_blk_rdwr_fifo_72b_2_64b_pkg::*;
#(
  parameter int unsigned IN_DEPTH_BITS  = 3,
  parameter int unsigned OUT_DEPTH_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  wr_data,
  input  logic                 wr_en,
  output logic                 full,
  input  logic                 rd_en,
  output logic [OUT_WIDTH-1:0] rd_data,
  output logic [OUT_WIDTH-1:0] rd_data_d1,
  output logic                 empty
);

  logic [IN_WIDTH-1:0]  in_head;
  logic                 in_empty;
  logic                 in_pop;
  logic [OUT_WIDTH-1:0] out_din;
  logic                 out_wr;
  logic                 out_nearly_full;

  cnt_t                 cnt;
  logic [OUT_WIDTH-1:0] residual;
  logic [OUT_WIDTH-1:0] residual_next;
  logic                 is_flush;
  logic                 step;
  logic [7:0]           sel;

  // new_bytes: in_head right-shifted by cnt bytes under the residual bytes;
  // at cnt=8 the window lands entirely in the zero pad, so no mux is needed.
  // tail_bytes: the unconsumed low bytes of in_head, left-justified.
  logic [IN_WIDTH+OUT_WIDTH-1:0] new_bytes;
  logic [IN_WIDTH+OUT_WIDTH-1:0] tail_bytes;

  fallthrough_small_fifo #(
    .WIDTH          (IN_WIDTH),
    .MAX_DEPTH_BITS (IN_DEPTH_BITS)
  ) u_in_fifo (
    .clk         (clk),
    .rst         (rst),
    .din         (wr_data),
    .wr_en       (wr_en),
    .rd_en       (in_pop),
    .dout        (in_head),
    .nearly_full (full),
    .empty       (in_empty)
  );

  fallthrough_small_fifo #(
    .WIDTH          (OUT_WIDTH),
    .MAX_DEPTH_BITS (OUT_DEPTH_BITS)
  ) u_out_fifo (
    .clk         (clk),
    .rst         (rst),
    .din         (out_din),
    .wr_en       (out_wr),
    .rd_en       (rd_en),
    .dout        (rd_data),
    .nearly_full (out_nearly_full),
    .empty       (empty)
  );

  always_comb begin
    is_flush      = (cnt == CNT_FLUSH);
    step          = !out_nearly_full && (is_flush || !in_empty);
    sel           = slice_top(cnt);
    new_bytes     = {{OUT_WIDTH{1'b0}}, in_head};
    tail_bytes    = {in_head, {OUT_WIDTH{1'b0}}};
    out_din       = residual | new_bytes[sel -: OUT_WIDTH];
    residual_next = is_flush ? '0 : tail_bytes[sel -: OUT_WIDTH];
    out_wr        = step;
    in_pop        = step && !is_flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      residual   <= '0;
      rd_data_d1 <= '0;
    end else begin
      if (step) begin
        residual <= residual_next;
        cnt      <= is_flush ? '0 : cnt + 1'b1;
      end
      if (rd_en) rd_data_d1 <= rd_data;
    end
  end

endmodule

// File: tb/tb_ddr2_blk_rdwr_fifo_72b_2_64b.sv
module tb_ddr2_blk_rdwr_fifo_72b_2_64b;

  logic        clk = 1'b0;
  logic        rst;
  logic [71:0] wr_data;
  logic        wr_en;
  logic        full;
  logic        rd_en;
  logic [63:0] rd_data;
  logic [63:0] rd_data_d1;
  logic        empty;

  always #5 clk = ~clk;

  ddr2_blk_rdwr_fifo_72b_2_64b #(
    .IN_DEPTH_BITS  (3),
    .OUT_DEPTH_BITS (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .full       (full),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_data_d1 (rd_data_d1),
    .empty      (empty)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the stream is just a byte queue; each output word is
  // the next 8 stream bytes, MSB first.
  logic [7:0]  bq [$];
  logic [63:0] obs_q [$];
  int          ramp_b;
  int          wr_cnt, out_cnt, cyc;
  int          first_pop_cyc, last_pop_cyc;
  bit          pend_d1;
  logic [63:0] last_exp;
  bit          saw_full;
  bit          use_rand;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] gen_word();
    logic [71:0] w;
    if (use_rand) begin
      w = {$urandom_range(255, 0), $urandom, $urandom};
    end else begin
      for (int unsigned j = 0; j < 9; j++) begin
        w[71 - 8*j -: 8] = ramp_b[7:0];
        ramp_b++;
      end
    end
    return w;
  endfunction

  // One clock: entered and left at a negedge.
  task automatic step(input bit want_wr, input bit want_rd);
    bit          wr, rd;
    logic [71:0] w;
    logic [63:0] exp;
    if (full) saw_full = 1'b1;
    if (pend_d1) chk("rd_data_d1", {8'h0, rd_data_d1}, {8'h0, last_exp});
    wr = want_wr && !full;
    rd = want_rd && !empty;
    pend_d1 = 1'b0;
    if (rd) begin
      if (bq.size() < 8) begin
        chk("unexpected_output", 72'(bq.size()), 72'd8);
      end else begin
        for (int unsigned j = 0; j < 8; j++) exp[63 - 8*j -: 8] = bq.pop_front();
        chk("rd_data", {8'h0, rd_data}, {8'h0, exp});
        last_exp = exp;
        pend_d1  = 1'b1;
      end
      obs_q.push_back(rd_data);
      if (out_cnt == 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
      out_cnt++;
    end
    if (wr) begin
      w = gen_word();
      for (int unsigned j = 0; j < 9; j++) bq.push_back(w[71 - 8*j -: 8]);
      wr_data = w;
      wr_cnt++;
    end
    wr_en = wr;
    rd_en = rd;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    cyc++;
  endtask

  task automatic phase_start();
    out_cnt = 0;
    wr_cnt  = 0;
    obs_q.delete();
  endtask

  task automatic write_n(input int n, input bit rd, input int budget);
    int c = 0;
    while (wr_cnt < n && c < budget) begin
      step(1'b1, rd);
      c++;
    end
    if (wr_cnt < n) chk("write_budget", 72'(wr_cnt), 72'(n));
  endtask

  task automatic drain();
    int idle = 0;
    int c = 0;
    while (idle < 16 && c < 400) begin
      if (empty) idle++; else idle = 0;
      step(1'b0, 1'b1);
      c++;
    end
    if (idle < 16) chk("drain_budget", 72'(idle), 72'd16);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst = 1'b0;
    bq.delete();
    pend_d1 = 1'b0;
    ramp_b  = 0;
    step(1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    ramp_b = 0; cyc = 0; pend_d1 = 1'b0; use_rand = 1'b0; saw_full = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state and idle
    chk("reset_empty", {71'h0, empty}, 72'd1);
    chk("reset_full", {71'h0, full}, 72'd0);
    chk("reset_d1", {8'h0, rd_data_d1}, 72'd0);
    phase_start();
    repeat (20) step(1'b0, 1'b1);
    chk("idle_outputs", 72'(out_cnt), 72'd0);

    // Byte-ramp group with latency check
    phase_start();
    step(1'b1, 1'b0);
    chk("latency_t1_empty", {71'h0, empty}, 72'd1);
    step(1'b1, 1'b0);
    chk("latency_t2_empty", {71'h0, empty}, 72'd0);
    write_n(8, 1'b0, 100);
    drain();
    chk("ramp_count", 72'(out_cnt), 72'd9);
    if (obs_q.size() == 9) begin
      chk("ramp_w0", {8'h0, obs_q[0]}, 72'h0001020304050607);
      chk("ramp_w1", {8'h0, obs_q[1]}, 72'h08090a0b0c0d0e0f);
      chk("ramp_w7", {8'h0, obs_q[7]}, 72'h38393a3b3c3d3e3f);
      chk("ramp_w8", {8'h0, obs_q[8]}, 72'h4041424344454647);
    end
    chk("ramp_model_left", 72'(bq.size()), 72'd0);

    // Sustained stream, reader always ready
    phase_start();
    write_n(64, 1'b1, 400);
    drain();
    chk("stream_count", 72'(out_cnt), 72'd72);
    chk("stream_span", 72'(last_pop_cyc - first_pop_cyc + 1), 72'd72);

    // Backpressure
    phase_start();
    saw_full = 1'b0;
    repeat (40) step(wr_cnt < 32, 1'b0);
    chk("bp_full_seen", {71'h0, saw_full}, 72'd1);
    chk("bp_stalled", {71'h0, wr_cnt < 32}, 72'd1);
    write_n(32, 1'b1, 400);
    drain();
    chk("bp_count", 72'(out_cnt), 72'd36);

    // Partial group
    use_rand = 1'b1;
    phase_start();
    write_n(3, 1'b1, 50);
    drain();
    chk("partial3_count", 72'(out_cnt), 72'd3);
    chk("partial3_residual", 72'(bq.size()), 72'd3);
    write_n(8, 1'b1, 50);
    drain();
    chk("partial8_count", 72'(out_cnt), 72'd9);
    chk("partial8_residual", 72'(bq.size()), 72'd0);

    // Reset mid-group
    phase_start();
    write_n(4, 1'b0, 50);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    do_reset();
    chk("midrst_empty", {71'h0, empty}, 72'd1);
    chk("midrst_full", {71'h0, full}, 72'd0);
    chk("midrst_d1", {8'h0, rd_data_d1}, 72'd0);
    phase_start();
    repeat (20) step(1'b0, 1'b1);
    chk("midrst_idle", 72'(out_cnt), 72'd0);
    use_rand = 1'b0;
    phase_start();
    write_n(8, 1'b1, 100);
    drain();
    chk("midrst_count", 72'(out_cnt), 72'd9);
    if (obs_q.size() > 0) chk("midrst_w0", {8'h0, obs_q[0]}, 72'h0001020304050607);

    // Random traffic
    use_rand = 1'b1;
    phase_start();
    begin
      int c = 0;
      while (wr_cnt < 48 && c < 2000) begin
        step(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        c++;
      end
      if (wr_cnt < 48) chk("rand_budget", 72'(wr_cnt), 72'd48);
    end
    drain();
    chk("rand_count", 72'(out_cnt), 72'd54);
    chk("rand_model_left", 72'(bq.size()), 72'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr2_blk_rdwr_fifo_72b_2_64b.md
# ddr2_blk_rdwr_fifo_72b_2_64b

Read-side width converter for the DDR2 block read/write path. It accepts 72-bit words returned from DRAM and re-packs them into 64-bit words. It is the inverse of the 64b-to-72b write-side packer: every 8 input words (576 bits) yield exactly 9 output words, with byte order preserved MSB-first. It sits between the DDR2 read-data capture and the 64-bit packet-side consumer, with a small fallthrough FIFO on each side of the repacking logic.

## Interface
- IN_DEPTH_BITS, 3, log2 depth of the 72-bit input FIFO.
- OUT_DEPTH_BITS, 3, log2 depth of the 64-bit output FIFO.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- wr_data  in  72  input word, MSB byte first in stream order.
- wr_en  in  1  write strobe. Asserting it while full is high is a protocol violation.
- full  out  1  input FIFO nearly_full.
- rd_en  in  1  pop strobe. Asserting it while empty is high is a protocol violation.
- rd_data  out  64  head of the output FIFO. Valid in the same cycle as rd_en (fallthrough).
- rd_data_d1  out  64  rd_data registered one cycle, i.e. valid the cycle after rd_en.
- empty  out  1  output FIFO empty.

## Operation
- Internal registers:
  - cnt, 4 bits, range 0..8.
  - residual, 64 bits, left-justified.
  - in_head is the input FIFO dout.
- Repack step:
  - A step fires when its condition holds.
  - A firing step writes one word to the output FIFO, and pops the input FIFO when the state uses an input.
- cnt=0: condition is input not empty and output not nearly_full.
  - Output in_head[71:8].
  - residual ← {in_head[7:0], 56'b0}.
  - cnt ← 1.
- cnt=k, k=1..7: condition is input not empty and output not nearly_full.
  - Output {residual[63 -: 8k], in_head[71 -: 64-8k]}.
  - residual ← in_head[8(k+1)-1:0], left-justified.
  - cnt ← k+1.
- cnt=8: condition is output not nearly_full only.
  - Output residual[63:0].
  - No input pop.
  - cnt ← 0, residual ← 0.
- Holding:
  - If the condition is false, nothing changes.
  - A partial group waits indefinitely in residual until the group completes.
- Arithmetic:
  - The output is always the concatenation of residual bytes followed by new input bytes.
  - Byte i of the stream appears in output word floor(i/8), at byte lane 7-(i mod 8) (MSB lane = 7).
- Reset:
  - cnt=0, residual=0, rd_data_d1=0, both FIFOs emptied.
  - Reset mid-group discards the partial group.
  - After reset: empty=1, full=0.
- Upstream obligation: block transfers are multiples of 8 input words. Trailing fewer than 8 words remain unflushed by design.

## Timing
- Fallthrough FIFOs:
  - A write in cycle t is visible as not-empty in cycle t+1.
  - dout is valid whenever not empty.
- Latency: wr_en at t → repack step at t+1 → empty deasserts at t+2.
- Throughput, input continuously available and consumer always reading:
  - 9 outputs per 9 cycles.
  - 8 inputs accepted per 9 cycles.
  - The cnt=8 cycle is an input bubble.
- Simultaneous wr_en and internal pop on the input FIFO is legal in any cycle. The same holds for internal write and rd_en on the output FIFO.
- Backpressure: output nearly_full stalls repacking, which fills the input FIFO, which raises full.

## Structure
- Shared package or defines:
  - Input width 72 and output width 64.
  - Constant GROUP_WORDS=8 (input words per group).
- Two instances of the existing fallthrough_small_fifo: WIDTH 72 on the input side, WIDTH 64 on the output side.
- The repack FSM stays in this module; no separate sub-module.
- The per-state slicing is a generate or indexed part-select on cnt, not a hand-written 9-way copy.

## Test plan
- Reset then idle:
  - empty=1, full=0, rd_data_d1=0.
  - No output appears in 20 cycles.
- Byte-ramp group: write 8 words where stream byte i = i, so word0 = 72'h000102030405060708.
  - Output 9 words: 64'h0001020304050607, 64'h08090a0b0c0d0e0f, …, 64'h38393a3b3c3d3e3f, 64'h4041424344454647.
  - empty deasserts 2 cycles after the first wr_en.
- Sustained stream: 64 input words back-to-back while honoring full, rd_en held high.
  - 72 outputs, all matching the ramp model.
  - wr_en is accepted 8 of every 9 cycles.
- Backpressure: rd_en=0 while writing 32 words.
  - full asserts.
  - No data loss: later draining yields 36 correct words.
  - The input FIFO never overflows.
- Partial group: write 3 words.
  - Exactly 3 outputs are produced and cnt stays at 3.
  - Then write 5 more: the remaining 6 outputs are correct.
- Reset mid-group: assert rst after 4 of 8 words.
  - Outputs stop, empty=1.
  - A fresh 8-word ramp group then yields exactly 9 correct words with no stale bytes.
